// File: rtl/bios_pkg.sv
// Shared BIOS protocol definitions: wire opcodes (common with the BIOS receiver),
// host command ops and the encoder state encoding.
package bios_pkg;

  typedef enum logic [7:0] {
    WOP_NOP       = 8'h00,
    WOP_BOOT      = 8'h01,
    WOP_RST       = 8'h02,
    WOP_READ      = 8'h03,
    WOP_WRITE     = 8'h04,
    WOP_ADR_LOWER = 8'h05,
    WOP_ADR_UPPER = 8'h06
  } wire_op_e;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_BOOT  = 3'd1,
    CMD_RST   = 3'd2,
    CMD_READ  = 3'd3,
    CMD_WRITE = 3'd4
  } cmd_op_e;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    UP_OP    = 4'd1,
    UP_A0    = 4'd2,
    UP_A1    = 4'd3,
    LO_OP    = 4'd4,
    LO_A0    = 4'd5,
    LO_A1    = 4'd6,
    CMD_OP   = 4'd7,
    CMD_ARG  = 4'd8,
    WAIT_RSP = 4'd9
  } enc_state_e;

  // Reserved host ops never reach the wire, so they simply map to NOP here.
  function automatic logic [7:0] cmd_to_wire(input logic [2:0] op);
    logic [7:0] b;
    case (op)
      CMD_NOP:   b = WOP_NOP;
      CMD_BOOT:  b = WOP_BOOT;
      CMD_RST:   b = WOP_RST;
      CMD_READ:  b = WOP_READ;
      CMD_WRITE: b = WOP_WRITE;
      default:   b = WOP_NOP;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bios_cmd_encoder_if.sv
// Command, protocol-stream and response signals of the BIOS command encoder.
// slave = encoder side, master = host/BIOS side.
interface bios_cmd_encoder_if #(
  parameter int ADDR_WIDTH = 31
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [2:0]            i_cmd_op;
  logic [ADDR_WIDTH:0]   i_cmd_addr;
  logic [7:0]            i_cmd_data;
  logic [7:0]            o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [7:0]            i_data;
  logic                  i_valid;
  logic                  o_in_ready;
  logic                  o_rsp_valid;
  logic [7:0]            o_rsp_data;
  logic                  o_rsp_err;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data, i_ready, i_data, i_valid,
    output o_cmd_ready, o_data, o_valid, o_in_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data, i_ready, i_data, i_valid,
    input  o_cmd_ready, o_data, o_valid, o_in_ready, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/bios_cmd_encoder.sv
// Host-side BIOS command encoder: serializes host requests into protocol bytes,
// resending address halves only when they differ from what the receiver holds.
module bios_cmd_encoder
  import bios_pkg::*;
#(
  parameter int ADDR_WIDTH  = 31,
  parameter int RSP_TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  bios_cmd_encoder_if.slave bus
);

  localparam int               CNT_W    = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RSP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  enc_state_e          state_r, state_s;
  logic [ADDR_WIDTH:0] addr_r;
  logic [7:0]          data_r;
  logic [2:0]          op_r;
  logic [15:0]         hi_r, lo_r;
  logic                hi_v_r, lo_v_r;
  logic [CNT_W-1:0]    cnt_r, cnt_s;

  logic                cmd_ready_r, valid_r, in_ready_r;
  logic [7:0]          data_out_r;
  logic                rsp_valid_r, rsp_err_r;
  logic [7:0]          rsp_data_r;

  logic                accept_s, out_hs_s, in_hs_s;
  logic [ADDR_WIDTH:0] cur_addr_s;
  logic [7:0]          cur_data_s;
  logic [2:0]          cur_op_s;
  logic                hi_miss_s, lo_miss_s, is_rw_s;
  logic                set_hi_s, set_lo_s, clr_cache_s;
  logic                rsp_valid_s, rsp_err_s;
  logic [7:0]          rsp_data_s;
  logic [7:0]          byte_s;
  logic                send_s;

  assign accept_s = bus.i_cmd_valid & cmd_ready_r;
  assign out_hs_s = valid_r & bus.i_ready;
  assign in_hs_s  = in_ready_r & bus.i_valid;

  // During the accept cycle the command is not latched yet, so decode the live inputs.
  assign cur_addr_s = accept_s ? bus.i_cmd_addr : addr_r;
  assign cur_data_s = accept_s ? bus.i_cmd_data : data_r;
  assign cur_op_s   = accept_s ? bus.i_cmd_op   : op_r;

  assign hi_miss_s = !hi_v_r || (cur_addr_s[31:16] != hi_r);
  assign lo_miss_s = !lo_v_r || (cur_addr_s[15:0] != lo_r);
  assign is_rw_s   = (cur_op_s == CMD_READ) || (cur_op_s == CMD_WRITE);

  // Next-state, cache-update and response decisions
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    set_hi_s    = 1'b0;
    set_lo_s    = 1'b0;
    clr_cache_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = 8'h00;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (is_rw_s) begin
          if (hi_miss_s)      state_s = UP_OP;
          else if (lo_miss_s) state_s = LO_OP;
          else                state_s = CMD_OP;
        end else if ((cur_op_s == CMD_NOP) || (cur_op_s == CMD_BOOT) || (cur_op_s == CMD_RST)) begin
          state_s = CMD_OP;
        end else begin
          state_s = IDLE;
        end
      end
      UP_OP: begin
        if (out_hs_s) state_s = UP_A0;
        else          state_s = UP_OP;
      end
      UP_A0: begin
        if (out_hs_s) state_s = UP_A1;
        else          state_s = UP_A0;
      end
      UP_A1: begin
        if (out_hs_s) begin
          set_hi_s = 1'b1;
          state_s  = lo_miss_s ? LO_OP : CMD_OP;
        end else begin
          state_s = UP_A1;
        end
      end
      LO_OP: begin
        if (out_hs_s) state_s = LO_A0;
        else          state_s = LO_OP;
      end
      LO_A0: begin
        if (out_hs_s) state_s = LO_A1;
        else          state_s = LO_A0;
      end
      LO_A1: begin
        if (out_hs_s) begin
          set_lo_s = 1'b1;
          state_s  = CMD_OP;
        end else begin
          state_s = LO_A1;
        end
      end
      CMD_OP: begin
        if (!out_hs_s) begin
          state_s = CMD_OP;
        end else begin
          case (cur_op_s)
            CMD_WRITE: state_s = CMD_ARG;
            CMD_READ: begin
              state_s = WAIT_RSP;
              cnt_s   = CNT_LOAD;
            end
            CMD_BOOT, CMD_RST: begin
              state_s     = IDLE;
              clr_cache_s = 1'b1;
            end
            default: state_s = IDLE;
          endcase
        end
      end
      CMD_ARG: begin
        if (out_hs_s) state_s = IDLE;
        else          state_s = CMD_ARG;
      end
      WAIT_RSP: begin
        // A byte in the expiry cycle takes priority over the timeout.
        if (in_hs_s) begin
          state_s     = IDLE;
          cnt_s       = CNT_ZERO;
          rsp_valid_s = 1'b1;
          rsp_data_s  = bus.i_data;
        end else if (cnt_r <= CNT_ONE) begin
          state_s     = IDLE;
          cnt_s       = CNT_ZERO;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Byte presented on the stream in the state being entered
  always_comb begin
    byte_s = 8'h00;
    case (state_s)
      UP_OP:   byte_s = WOP_ADR_UPPER;
      UP_A0:   byte_s = cur_addr_s[23:16];
      UP_A1:   byte_s = cur_addr_s[31:24];
      LO_OP:   byte_s = WOP_ADR_LOWER;
      LO_A0:   byte_s = cur_addr_s[7:0];
      LO_A1:   byte_s = cur_addr_s[15:8];
      CMD_OP:  byte_s = cmd_to_wire(cur_op_s);
      CMD_ARG: byte_s = cur_data_s;
      default: byte_s = 8'h00;
    endcase
  end

  assign send_s = !((state_s == IDLE) || (state_s == WAIT_RSP));

  // FSM state, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      cmd_ready_r <= 1'b1;
      valid_r     <= 1'b0;
      data_out_r  <= 8'h00;
      in_ready_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cmd_ready_r <= (state_s == IDLE);
      valid_r     <= send_s;
      data_out_r  <= byte_s;
      in_ready_r  <= (state_s == WAIT_RSP);
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  // Command latch and receiver-side address cache
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      data_r <= 8'h00;
      op_r   <= 3'd0;
      hi_r   <= 16'h0000;
      lo_r   <= 16'h0000;
      hi_v_r <= 1'b0;
      lo_v_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r <= bus.i_cmd_addr;
        data_r <= bus.i_cmd_data;
        op_r   <= bus.i_cmd_op;
      end
      if (clr_cache_s) begin
        hi_v_r <= 1'b0;
        lo_v_r <= 1'b0;
      end else begin
        if (set_hi_s) begin
          hi_r   <= addr_r[31:16];
          hi_v_r <= 1'b1;
        end
        if (set_lo_s) begin
          lo_r   <= addr_r[15:0];
          lo_v_r <= 1'b1;
        end
      end
    end
  end

  assign bus.o_cmd_ready = cmd_ready_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_data      = data_out_r;
  assign bus.o_in_ready  = in_ready_r;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_data  = rsp_data_r;
  assign bus.o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_bios_cmd_encoder.sv
// Bench for bios_cmd_encoder: directed and random commands checked against a
// byte-queue model of the protocol and its receiver-side address cache.
module tb_bios_cmd_encoder;
  import bios_pkg::*;

  localparam int RSP_TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rand_ready = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] m_hi, m_lo;
  logic        m_hv, m_lv;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  bios_cmd_encoder_if #(.ADDR_WIDTH(31)) bus ();

  bios_cmd_encoder #(.ADDR_WIDTH(31), .RSP_TIMEOUT(RSP_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected bytes for one command, updating the model of the receiver's address registers.
  task automatic model_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] data);
    exp_q.delete();
    if (op == 3'd3 || op == 3'd4) begin
      if (!m_hv || addr[31:16] != m_hi) begin
        exp_q.push_back(8'h06); exp_q.push_back(addr[23:16]); exp_q.push_back(addr[31:24]);
        m_hi = addr[31:16]; m_hv = 1'b1;
      end
      if (!m_lv || addr[15:0] != m_lo) begin
        exp_q.push_back(8'h05); exp_q.push_back(addr[7:0]); exp_q.push_back(addr[15:8]);
        m_lo = addr[15:0]; m_lv = 1'b1;
      end
      exp_q.push_back({5'd0, op});
      if (op == 3'd4) exp_q.push_back(data);
    end else if (op <= 3'd2) begin
      exp_q.push_back({5'd0, op});
      if (op != 3'd0) begin
        m_hv = 1'b0; m_lv = 1'b0;
      end
    end
  endtask

  // Stream monitor: collect handshaken bytes, check hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.o_valid), 32'(1));
        check("hold_data", 32'(bus.o_data), 32'(prev_data));
      end
      if (bus.o_valid && bus.i_ready) got_q.push_back(bus.o_data);
      prev_stall <= bus.o_valid && !bus.i_ready;
      prev_data  <= bus.o_data;
    end
  end

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] data,
                       output int acc);
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = data;
    acc = -1;
    for (int n = 0; n < 300 && acc < 0; n++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) acc = cyc;
    end
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = $urandom;
    bus.i_cmd_data  = 8'($urandom);
    if (acc < 0) check("cmd_accept", 32'(bus.o_cmd_ready), 32'(1));
  endtask

  // Issue one command, wait for completion (and response for READ), compare bytes.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] data,
                         input int d, input logic [7:0] rdata);
    int acc, ent, rc, n;
    logic seen, re;
    logic [7:0] rd;
    model_cmd(op, addr, data);
    issue(op, addr, data, acc);
    @(negedge clk);
    check("first_valid", 32'(bus.o_valid), 32'(exp_q.size() != 0));
    check("in_ready_busy", 32'(bus.o_in_ready), 32'(0));
    if (op == 3'd3) begin
      n = 0;
      while (!bus.o_in_ready && n < 300) begin @(negedge clk); n++; end
      check("wait_rsp_entry", 32'(bus.o_in_ready), 32'(1));
      ent = cyc; seen = 1'b0; rc = 0; re = 1'b0; rd = 8'h00;
      for (int k = 0; k < RSP_TO + 8 && !seen; k++) begin
        if (bus.o_rsp_valid) begin
          seen = 1'b1; rc = cyc; rd = bus.o_rsp_data; re = bus.o_rsp_err;
          check("ready_with_rsp", 32'(bus.o_cmd_ready), 32'(1));
          check("in_ready_after", 32'(bus.o_in_ready), 32'(0));
        end else begin
          bus.i_valid = (d == k);
          bus.i_data  = rdata;
          @(negedge clk);
        end
      end
      bus.i_valid = 1'b0;
      check("rsp_seen", 32'(seen), 32'(1));
      check("rsp_latency", 32'(rc - ent), (d >= 0) ? 32'(d + 1) : 32'(RSP_TO));
      check("rsp_err", 32'(re), 32'(d < 0));
      check("rsp_data", 32'(rd), (d >= 0) ? 32'(rdata) : 32'(0));
      @(negedge clk);
      check("rsp_pulse_width", 32'(bus.o_rsp_valid), 32'(0));
    end else begin
      n = 0;
      while (!bus.o_cmd_ready && n < 300) begin @(negedge clk); n++; end
      check("cmd_done", 32'(bus.o_cmd_ready), 32'(1));
      if (!rand_ready) check("ready_latency", 32'(cyc - acc), 32'(exp_q.size() + 1));
    end
    check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
  endtask

  initial begin
    int acc;
    logic [2:0] op;
    logic [15:0] hi, lo;
    int d;
    rst_n = 1'b0;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_op = 3'd0; bus.i_cmd_addr = '0; bus.i_cmd_data = 8'h00;
    bus.i_valid = 1'b0; bus.i_data = 8'h00;
    m_hi = 16'h0000; m_lo = 16'h0000; m_hv = 1'b0; m_lv = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'(1));
    check("rst_valid", 32'(bus.o_valid), 32'(0));
    check("rst_data", 32'(bus.o_data), 32'(0));
    check("rst_in_ready", 32'(bus.o_in_ready), 32'(0));
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(bus.o_rsp_data), 32'(0));
    check("rst_rsp_err", 32'(bus.o_rsp_err), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.o_cmd_ready), 32'(1));

    run_cmd(3'd4, 32'h0000_1234, 8'hAB, -1, 8'h00);
    run_cmd(3'd4, 32'h0000_1234, 8'hCD, -1, 8'h00);
    run_cmd(3'd4, 32'h0000_1235, 8'hEE, -1, 8'h00);
    run_cmd(3'd3, 32'h0000_1235, 8'h00, 3, 8'h5A);
    run_cmd(3'd3, 32'h0000_1235, 8'h00, -1, 8'h00);
    run_cmd(3'd3, 32'h0000_1235, 8'h00, RSP_TO - 1, 8'h77);
    run_cmd(3'd3, 32'h0000_1235, 8'h00, 0, 8'hC3);

    // Stray response bytes while idle must be back-pressured.
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_data = 8'h99;
    repeat (3) begin
      @(negedge clk);
      check("stray_in_ready", 32'(bus.o_in_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;

    rand_ready = 1'b1;
    run_cmd(3'd4, 32'hCAFE_0042, 8'h11, -1, 8'h00);
    rand_ready = 1'b0;
    run_cmd(3'd2, 32'h0, 8'h00, -1, 8'h00);
    run_cmd(3'd4, 32'hCAFE_0042, 8'h22, -1, 8'h00);
    run_cmd(3'd0, 32'h0, 8'h00, -1, 8'h00);
    run_cmd(3'd5, 32'hCAFE_0042, 8'h00, -1, 8'h00);
    run_cmd(3'd1, 32'h0, 8'h00, -1, 8'h00);

    // Reset while the low address byte is on the wire.
    model_cmd(3'd4, 32'hDEAD_BEEF, 8'h33);
    issue(3'd4, 32'hDEAD_BEEF, 8'h33, acc);
    repeat (5) @(negedge clk);
    check("lo_a0_data", 32'(bus.o_data), 32'(8'hEF));
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.o_valid), 32'(0));
    check("arst_data", 32'(bus.o_data), 32'(0));
    check("arst_cmd_ready", 32'(bus.o_cmd_ready), 32'(1));
    m_hv = 1'b0; m_lv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    @(negedge clk);
    check("arst_release_ready", 32'(bus.o_cmd_ready), 32'(1));
    run_cmd(3'd3, 32'hDEAD_BEEF, 8'h00, 2, 8'hA5);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 3'd4;
        4, 5, 6:    op = 3'd3;
        default:    op = 3'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 2))
        0:       hi = 16'h0000;
        1:       hi = 16'h0001;
        default: hi = 16'hBEEF;
      endcase
      case ($urandom_range(0, 2))
        0:       lo = 16'h1234;
        1:       lo = 16'h1235;
        default: lo = 16'h0000;
      endcase
      rand_ready = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, RSP_TO - 1));
      run_cmd(op, {hi, lo}, 8'($urandom), d, 8'($urandom));
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
